// File: rtl/hyperbus_pkg.sv
// Shared types and default constants for the HyperBus read-capture delay calibrator.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        SETTLE,
        SAMPLE,
        EVAL,
        FINISH
    } state_e;

    localparam int unsigned DEF_TAP_W         = 5;
    localparam int unsigned DEF_SETTLE_CYCLES = 8;
    localparam int unsigned DEF_SAMPLES       = 16;
    localparam int unsigned DEF_TIMEOUT       = 1024;

    // Mid-scale tap: the safest guess when no calibration result is available.
    function automatic int unsigned default_tap(input int unsigned tap_w);
        return 2 ** (tap_w - 1);
    endfunction

endpackage

// File: rtl/hyperbus_delay_window_tracker.sv
// Tracks the current run of passing taps and keeps the longest one seen (lowest wins ties).
module hyperbus_delay_window_tracker #(
    parameter int unsigned TAP_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             eval_i,
    input  logic             pass_i,
    input  logic             last_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic             best_valid_o,
    output logic [TAP_W-1:0] best_lo_o,
    output logic [TAP_W-1:0] best_hi_o
);

    logic             run_open_q, run_open_d;
    logic [TAP_W-1:0] run_lo_q, run_lo_d, best_lo_q, best_lo_d;
    logic [TAP_W:0]   run_len_q, run_len_d, best_len_q, best_len_d;
    logic [TAP_W-1:0] cand_lo;
    logic [TAP_W:0]   cand_len;
    logic             cand_close;

    // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        run_open_d = run_open_q;
        run_lo_d   = run_lo_q;
        run_len_d  = run_len_q;
        best_lo_d  = best_lo_q;
        best_len_d = best_len_q;
        cand_lo    = run_lo_q;
        cand_len   = run_len_q;
        cand_close = 1'b0;
        if (clear_i) begin
            run_open_d = 1'b0;
            run_lo_d   = '0;
            run_len_d  = '0;
            best_lo_d  = '0;
            best_len_d = '0;
        end else if (eval_i) begin
            if (pass_i) begin
                cand_lo    = run_open_q ? run_lo_q : tap_i;
                cand_len   = run_open_q ? run_len_q + 1'b1 : (TAP_W+1)'(1);
                cand_close = last_i;
            end else begin
                cand_close = run_open_q;
            end
            run_open_d = pass_i && !last_i;
            run_lo_d   = cand_lo;
            run_len_d  = pass_i ? cand_len : '0;
            if (cand_close && (cand_len > best_len_q)) begin
                best_lo_d  = cand_lo;
                best_len_d = cand_len;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_open_q <= 1'b0;
            run_lo_q   <= '0;
            run_len_q  <= '0;
            best_lo_q  <= '0;
            best_len_q <= '0;
        end else begin
            run_open_q <= run_open_d;
            run_lo_q   <= run_lo_d;
            run_len_q  <= run_len_d;
            best_lo_q  <= best_lo_d;
            best_len_q <= best_len_d;
        end
    end

    // A full-width run (length 2**TAP_W) wraps the low bits to 0, which still lands hi on the last tap.
    assign best_valid_o = (best_len_q != '0);
    assign best_lo_o    = best_lo_q;
    assign best_hi_o    = best_lo_q + best_len_q[TAP_W-1:0] - 1'b1;

endmodule

// File: rtl/hyperbus_delay_calib.sv
// HyperBus read-capture delay calibrator: sweeps every tap, keeps the widest passing window, parks in its centre.
// Define HYPERBUS_DELAY_CALIB_TIMEOUT_EN to add the sample-starvation watchdog.
module hyperbus_delay_calib
    import hyperbus_pkg::*;
#(
    parameter int unsigned TAP_W         = DEF_TAP_W,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned SAMPLES       = DEF_SAMPLES,
    parameter int unsigned DEFAULT_TAP   = default_tap(TAP_W),
    parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sample_valid_i,
    input  logic             sample_ok_i,
    output logic [TAP_W-1:0] delay_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [TAP_W-1:0] win_lo_o,
    output logic [TAP_W-1:0] win_hi_o,
    output logic [TAP_W-1:0] center_o
);

    localparam int unsigned      CNT_MAX     = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int unsigned      CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = '1;
    localparam logic [TAP_W-1:0] DEF_CODE    = TAP_W'(DEFAULT_TAP);

    state_e           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d, delay_q, delay_d;
    logic [TAP_W-1:0] win_lo_q, win_lo_d, win_hi_q, win_hi_d, center_q, center_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d, fail_q, fail_d, tout_q, tout_d;
    logic             trk_clear, trk_eval, best_valid, wd_expire, fin;
    logic [TAP_W-1:0] best_lo, best_hi;

`ifdef HYPERBUS_DELAY_CALIB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    // Held at zero outside SAMPLE, so each SAMPLE entry starts a fresh count.
    always_comb begin
        wd_d = '0;
        if ((state_q == SAMPLE) && !sample_valid_i) wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    assign wd_expire = (state_q == SAMPLE) && !sample_valid_i && (wd_q == WD_W'(TIMEOUT - 1));
    assign timeout_o = tout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        delay_d   = delay_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        tout_d    = tout_q;
        win_lo_d  = win_lo_q;
        win_hi_d  = win_hi_q;
        center_d  = center_q;
        trk_clear = 1'b0;
        trk_eval  = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d   = SET;
                tap_d     = '0;
                delay_d   = '0;
                fail_d    = 1'b0;
                tout_d    = 1'b0;
                trk_clear = 1'b1;
            end
            SET: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: if (cnt_q == SETTLE_LAST) begin
                state_d = SAMPLE;
                cnt_d   = '0;
                pass_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            SAMPLE: if (wd_expire) begin
                state_d = FINISH;
                fail_d  = 1'b1;
                tout_d  = 1'b1;
            end else if (sample_valid_i) begin
                pass_d = pass_q & sample_ok_i;
                if (cnt_q == SAMPLE_LAST) state_d = EVAL;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            EVAL: begin
                trk_eval = 1'b1;
                if (tap_q == LAST_TAP) begin
                    state_d = FINISH;
                end else begin
                    state_d = SET;
                    tap_d   = tap_q + 1'b1;
                    delay_d = tap_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (best_valid && !tout_q) begin
                    win_lo_d = best_lo;
                    win_hi_d = best_hi;
                    center_d = best_lo + ((best_hi - best_lo) >> 1);
                    delay_d  = center_d;
                end else begin
                    fail_d   = 1'b1;
                    delay_d  = DEF_CODE;
                    win_lo_d = '0;
                    win_hi_d = '0;
                    center_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            delay_q  <= DEF_CODE;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            tout_q   <= 1'b0;
            win_lo_q <= '0;
            win_hi_q <= '0;
            center_q <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            delay_q  <= delay_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            tout_q   <= tout_d;
            win_lo_q <= win_lo_d;
            win_hi_q <= win_hi_d;
            center_q <= center_d;
        end
    end

    hyperbus_delay_window_tracker #(
        .TAP_W(TAP_W)
    ) u_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (trk_clear),
        .eval_i      (trk_eval),
        .pass_i      (pass_q),
        .last_i      (tap_q == LAST_TAP),
        .tap_i       (tap_q),
        .best_valid_o(best_valid),
        .best_lo_o   (best_lo),
        .best_hi_o   (best_hi)
    );

    // Results are presented during the FINISH cycle itself so they line up with the done pulse.
    assign fin      = (state_q == FINISH);
    assign busy_o   = (state_q != IDLE);
    assign done_o   = fin;
    assign delay_o  = fin ? delay_d  : delay_q;
    assign fail_o   = fin ? fail_d   : fail_q;
    assign win_lo_o = fin ? win_lo_d : win_lo_q;
    assign win_hi_o = fin ? win_hi_d : win_hi_q;
    assign center_o = fin ? center_d : center_q;

endmodule

// File: tb/tb_hyperbus_delay_calib.sv
// Scoreboard bench for hyperbus_delay_calib: expected results queued per calibration, compared on done_o.
`timescale 1ns/1ps
module tb_hyperbus_delay_calib;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, sample_valid_i, sample_ok_i;
    logic [4:0] delay_o, win_lo_o, win_hi_o, center_o;
    logic       busy_o, done_o, fail_o, timeout_o;

    hyperbus_delay_calib #(
        .TAP_W(5), .SETTLE_CYCLES(8), .SAMPLES(16), .DEFAULT_TAP(16), .TIMEOUT(64)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .sample_valid_i(sample_valid_i), .sample_ok_i(sample_ok_i),
        .delay_o(delay_o), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .timeout_o(timeout_o), .win_lo_o(win_lo_o), .win_hi_o(win_hi_o), .center_o(center_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       fail;
        logic       tout;
        logic [4:0] lo;
        logic [4:0] hi;
        logic [4:0] center;
        logic [4:0] delay;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Read-back target model: pass mask per tap plus fault knobs.
    logic [31:0] mask       = '0;
    bit          rand_valid = 1'b0;
    bit          poison     = 1'b0;
    int          inj_tap    = -1;
    int          inj_k      = -1;
    int          stall_tap  = -1;
    int          k          = 0;
    logic [4:0]  prev_delay = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    function automatic exp_t mk(input logic f, input logic t, input logic [4:0] lo,
                                input logic [4:0] hi, input logic [4:0] c, input logic [4:0] d);
        exp_t e;
        e.fail = f; e.tout = t; e.lo = lo; e.hi = hi; e.center = c; e.delay = d;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] m);
        int bs = 0, bl = 0, cs = 0, cl = 0;
        for (int t = 0; t <= 32; t++) begin
            if (t < 32 && m[t]) begin
                if (cl == 0) cs = t;
                cl++;
            end else begin
                if (cl > bl) begin bl = cl; bs = cs; end
                cl = 0;
            end
        end
        if (bl == 0) return mk(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd16);
        return mk(1'b0, 1'b0, 5'(bs), 5'(bs + bl - 1), 5'(bs + (bl - 1) / 2), 5'(bs + (bl - 1) / 2));
    endfunction

    // k counts cycles since the delay code last changed; k=0 is the SET cycle of a tap.
    initial begin
        sample_valid_i = 1'b0;
        sample_ok_i    = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (delay_o != prev_delay) k = 0;
            else                       k++;
            prev_delay     = delay_o;
            sample_valid_i = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (int'(delay_o) == stall_tap) sample_valid_i = 1'b0;
            sample_ok_i = sample_valid_i ? mask[delay_o] : 1'($urandom_range(0, 1));
            if (poison && k < 9) sample_ok_i = 1'b0;
            if (int'(delay_o) == inj_tap && k == inj_k) sample_ok_i = 1'b0;
        end
    end

    task automatic run_cal(input string name, input exp_t e, input int exp_cyc, input bit mid_start);
        int n    = 0;
        bit seen = 1'b0;
        exp_q.push_back(e);
        start_i = 1'b1;
        while (!seen && n < 4000) begin
            tick();
            n++;
            start_i = mid_start && (n == 300);
            if (n == 1) begin
                check({name, "_busy_start"}, busy_o, 1);
                check({name, "_fail_clr"}, fail_o, 0);
                check({name, "_tout_clr"}, timeout_o, 0);
                check({name, "_tap0"}, delay_o, 0);
            end
            if (done_o) seen = 1'b1;
        end
        start_i = 1'b0;
        if (!seen) begin
            check({name, "_done_seen"}, 0, 1);
            void'(exp_q.pop_front());
        end else begin
            exp_t x;
            x = exp_q.pop_front();
            check({name, "_busy_at_done"}, busy_o, 1);
            check({name, "_fail"}, fail_o, x.fail);
            check({name, "_timeout"}, timeout_o, x.tout);
            check({name, "_win_lo"}, win_lo_o, x.lo);
            check({name, "_win_hi"}, win_hi_o, x.hi);
            check({name, "_center"}, center_o, x.center);
            check({name, "_delay"}, delay_o, x.delay);
            if (exp_cyc > 0) check({name, "_cycles"}, n, exp_cyc);
            tick();
            check({name, "_done_pulse"}, done_o, 0);
            check({name, "_busy_drop"}, busy_o, 0);
            check({name, "_delay_hold"}, delay_o, x.delay);
            check({name, "_fail_hold"}, fail_o, x.fail);
        end
    endtask

    initial begin
        int n;
        rst_i   = 1'b1;
        start_i = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_fail", fail_o, 0);
        check("rst_tout", timeout_o, 0);
        check("rst_delay", delay_o, 16);
        check("rst_win", {win_lo_o, win_hi_o, center_o}, 0);
        rst_i = 1'b0;
        tick();

        // Window 10..20, poisoned settle samples, start pulse while busy.
        mask   = 32'h001F_FC00;
        poison = 1'b1;
        run_cal("win10_20", mk(0, 0, 5'd10, 5'd20, 5'd15, 5'd15), 833, 1'b1);
        poison = 1'b0;

        mask = 32'h00F0_0078;
        run_cal("tie_low", mk(0, 0, 5'd3, 5'd6, 5'd4, 5'd4), 833, 1'b0);
        mask = 32'h03F0_0078;
        run_cal("longer_hi", mk(0, 0, 5'd20, 5'd25, 5'd22, 5'd22), 833, 1'b0);

        mask = 32'h0;
        run_cal("no_pass", mk(1, 0, 5'd0, 5'd0, 5'd0, 5'd16), 833, 1'b0);

        mask    = 32'h0007_FF00;
        inj_tap = 12;
        inj_k   = 23;
        run_cal("one_bad", mk(0, 0, 5'd13, 5'd18, 5'd15, 5'd15), 833, 1'b0);
        inj_tap = -1;

        mask = 32'hFFFF_FFFF;
        run_cal("all_pass", mk(0, 0, 5'd0, 5'd31, 5'd15, 5'd15), 833, 1'b0);
        mask = 32'h8000_0000;
        run_cal("last_only", mk(0, 0, 5'd31, 5'd31, 5'd31, 5'd31), 833, 1'b0);

        mask       = $urandom;
        rand_valid = 1'b1;
        run_cal("random", model(mask), 0, 1'b0);
        rand_valid = 1'b0;

        // Reset in the middle of tap 7 sampling, with a start in the same cycle.
        mask    = 32'h001F_FC00;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!(delay_o == 5'd7 && k == 15) && n < 2000) begin
            tick();
            n++;
        end
        check("reach_tap7", n < 2000, 1);
        rst_i   = 1'b1;
        start_i = 1'b1;
        tick();
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_delay", delay_o, 16);
        check("mid_rst_status", {done_o, fail_o, timeout_o}, 0);
        check("mid_rst_win", {win_lo_o, win_hi_o, center_o}, 0);
        rst_i   = 1'b0;
        start_i = 1'b0;
        tick();
        check("rst_start_ignored", busy_o, 0);
        run_cal("after_rst", mk(0, 0, 5'd10, 5'd20, 5'd15, 5'd15), 833, 1'b0);

        // Samples stop arriving at tap 4.
        mask      = 32'hFFFF_FFFF;
        stall_tap = 4;
`ifdef HYPERBUS_DELAY_CALIB_TIMEOUT_EN
        run_cal("wdog", mk(1, 1, 5'd0, 5'd0, 5'd0, 5'd16), 178, 1'b0);
`else
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (400) tick();
        check("stall_busy", busy_o, 1);
        check("stall_tout", timeout_o, 0);
        check("stall_delay", delay_o, 4);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("stall_rst_busy", busy_o, 0);
`endif
        stall_tap = -1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_delay_calib.md
HYPERBUS_DELAY_CALIB -- requirements
Module: hyperbus_delay_calib

Interface
REQ-001 SHALL have parameter TAP_W, default 5, delay tap code width (2**TAP_W taps).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8, idle cycles after each tap change.
REQ-003 SHALL have parameter SAMPLES, default 16, valid samples evaluated per tap.
REQ-004 SHALL have parameter DEFAULT_TAP, default 2**(TAP_W-1), tap driven when idle, after reset and after failure.
REQ-005 SHALL have parameter TIMEOUT, default 1024, watchdog limit in cycles (used only under REQ-031).
REQ-006 Ports: clk_i  in  1  clock; one clock, all logic on rising edge.
REQ-007 Ports: rst_i  in  1  reset, synchronous, active-high.
REQ-008 Ports: start_i  in  1  calibration request, sampled in IDLE only.
REQ-009 Ports: sample_valid_i  in  1  a read-back sample is present this cycle.
REQ-010 Ports: sample_ok_i  in  1  sample matched expected pattern; qualified by sample_valid_i.
REQ-011 Ports: delay_o  out  TAP_W  tap code driving the delay line.
REQ-012 Ports: busy_o  out  1  calibration in progress.
REQ-013 Ports: done_o  out  1  one-cycle pulse at completion (pass or fail).
REQ-014 Ports: fail_o  out  1  sticky; no passing tap found or watchdog abort; cleared on next start.
REQ-015 Ports: timeout_o  out  1  sticky; watchdog abort; cleared on next start.
REQ-016 Ports: win_lo_o, win_hi_o, center_o  out  TAP_W each  best window bounds and selected tap.

Function
REQ-017 FSM states SHALL be IDLE, SET, SETTLE, SAMPLE, EVAL, FINISH.
REQ-018 IDLE->SET on start_i; tap counter SHALL be 0; fail_o/timeout_o cleared; run trackers cleared.
REQ-019 SET SHALL drive delay_o=tap for one cycle then enter SETTLE.
REQ-020 SETTLE SHALL count exactly SETTLE_CYCLES cycles; sample_valid_i ignored there.
REQ-021 SAMPLE SHALL count SAMPLES cycles with sample_valid_i=1; tap passes iff every counted sample has sample_ok_i=1; a failing sample does not shorten collection.
REQ-022 EVAL (one cycle): pass extends current run (start recorded on first pass); fail closes run; run strictly longer than best replaces best (ties keep the lower window).
REQ-023 EVAL: tap < 2**TAP_W-1 -> tap+1, go SET; last tap -> close open run, go FINISH; no wrap to 0.
REQ-024 FINISH: best found -> center_o=win_lo_o+((win_hi_o-win_lo_o)>>1) (floor), delay_o=center_o; none -> fail_o=1, delay_o=DEFAULT_TAP, win/center=0; done_o pulses; next state IDLE.
REQ-025 busy_o SHALL be 1 in every state except IDLE; start_i while busy SHALL be ignored.
REQ-026 delay_o SHALL hold the calibrated tap in IDLE until the next start or reset.
REQ-027 Arithmetic SHALL be unsigned TAP_W+1 bits for run length; all 2**TAP_W taps passing gives win 0..2**TAP_W-1.

Reset
REQ-028 rst_i at any cycle, including mid-calibration, SHALL force IDLE, delay_o=DEFAULT_TAP, busy_o=0, done_o=0, fail_o=0, timeout_o=0, win_lo_o=win_hi_o=center_o=0.
REQ-029 A start_i asserted in the reset cycle SHALL be ignored.

Configuration
REQ-030 Macro HYPERBUS_DELAY_CALIB_TIMEOUT_EN SHALL gate the sample watchdog.
REQ-031 Defined: TIMEOUT consecutive SAMPLE cycles without sample_valid_i -> FINISH with fail_o=1, timeout_o=1, delay_o=DEFAULT_TAP; counter restarts on each valid sample and on SAMPLE entry.
REQ-032 Undefined: SAMPLE waits indefinitely; timeout_o tied 0; no watchdog counter synthesized.

Structure
REQ-033 hyperbus_pkg SHALL hold the FSM state enum type and default tap/settle/sample constants.
REQ-034 Best-window bookkeeping (current/best start, length) SHALL be a sub-module hyperbus_delay_window_tracker; FSM/counters stay in the top.

Verification
REQ-035 TAP_W=5, ok=1 only for taps 10..20, valid every cycle -> done_o after 32 taps, win 10/20, center_o=15, delay_o=15.
REQ-036 Two windows 3..6 and 20..23 (equal length) -> win 3/6, center_o=4; then 20..25 longer -> win 20/25, center_o=22.
REQ-037 ok=0 always -> fail_o=1, delay_o=DEFAULT_TAP=16, done_o one pulse, busy_o drops next cycle.
REQ-038 One failing sample (sample 15 of tap 12) inside window 8..18 -> two runs 8..11 and 13..18, win 13/18, center_o=15.
REQ-039 rst_i asserted during SAMPLE of tap 7 -> next cycle IDLE, delay_o=16, all status 0; fresh start_i recalibrates from tap 0.
REQ-040 With HYPERBUS_DELAY_CALIB_TIMEOUT_EN, TIMEOUT=64, sample_valid_i held 0 at tap 4 -> abort after 64 cycles, timeout_o=1, fail_o=1; without macro bench stays busy.
